// File: rtl/mips_pipeline_wrapper_pkg.sv
// Shared types for the 5-stage MIPS-subset pipeline: encodings, ALU ops,
// forwarding selects and the four pipeline-register structs.
package mips_pipeline_wrapper_pkg;
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [31:0] NOP     = 32'h0000_0020;

   typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
   typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_sel_e;

   typedef struct packed {
      logic [31:0] pc1;
      logic [31:0] instr;
   } if_id_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        branch;
      logic        alu_src;
      alu_op_e     alu_op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [31:0] rs_val;
      logic [31:0] rt_val;
      logic [31:0] imm;
      logic [31:0] pc1;
   } id_ex_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic [4:0]  dest;
      logic [31:0] alu_res;
      logic [31:0] store_val;
   } ex_mem_t;

   typedef struct packed {
      logic        reg_write;
      logic        mem_read;
      logic [4:0]  dest;
      logic [31:0] alu_res;
      logic [31:0] load_val;
   } mem_wb_t;

   localparam if_id_t IF_ID_BUBBLE = '{pc1: 32'd0, instr: NOP};
endpackage

// File: rtl/mips_pipeline_wrapper_hazard_unit.sv
// Operand forwarding selects, load-use stall and control-flow flushes.
module mips_pipeline_wrapper_hazard_unit
   import mips_pipeline_wrapper_pkg::*;
(
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rs,
   input  logic [4:0] ex_rt,
   input  logic       mem_reg_write,
   input  logic [4:0] mem_dest,
   input  logic       wb_reg_write,
   input  logic [4:0] wb_dest,
   input  logic       branch_taken,
   input  logic       jump,
   output fwd_sel_e   fwd_a,
   output fwd_sel_e   fwd_b,
   output logic       stall,
   output logic       flush_if_id,
   output logic       flush_id_ex
);
   logic load_use;

   always_comb begin
      fwd_a = FWD_NONE;
      fwd_b = FWD_NONE;
      if (mem_reg_write && mem_dest != 5'd0 && mem_dest == ex_rs)   fwd_a = FWD_MEM;
      else if (wb_reg_write && wb_dest != 5'd0 && wb_dest == ex_rs) fwd_a = FWD_WB;
      if (mem_reg_write && mem_dest != 5'd0 && mem_dest == ex_rt)   fwd_b = FWD_MEM;
      else if (wb_reg_write && wb_dest != 5'd0 && wb_dest == ex_rt) fwd_b = FWD_WB;
   end

   // A taken branch overrides both the stall and any jump sitting in ID.
   assign load_use    = ex_mem_read && (ex_rt == id_rs || ex_rt == id_rt);
   assign stall       = load_use && !branch_taken;
   assign flush_id_ex = branch_taken || load_use;
   assign flush_if_id = branch_taken || (jump && !load_use);
endmodule

// File: rtl/mips_pipeline_wrapper_stages.sv
// Pipeline stage modules and the instruction/data/register storage they own.
module mips_imem
   import mips_pipeline_wrapper_pkg::*;
#(parameter int DEPTH = 256)
(
   input  logic [$clog2(DEPTH)-1:0] addr,
   output logic [31:0]              rdata
);
   logic [31:0] memory [DEPTH] = '{default: NOP};
   assign rdata = memory[addr];
endmodule

module mips_dmem #(parameter int DEPTH = 256)
(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);
   logic [31:0] memory [DEPTH] = '{default: 32'd0};
   always_ff @(posedge clk) if (we) memory[addr] <= wdata;
   assign rdata = memory[addr];
endmodule

module mips_fetch #(parameter int DEPTH = 256)
(
   input  logic [$clog2(DEPTH)-1:0] pc_idx,
   output logic [31:0]              instr
);
   mips_imem #(.DEPTH(DEPTH)) InstructionMemory (.addr(pc_idx), .rdata(instr));
endmodule

module mips_regfile
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);
   logic [31:0] registers [32];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) for (int i = 0; i < 32; i++) registers[i] <= '0;
      else if (we && wa != 5'd0) registers[wa] <= wd;
   end

   // Write-through so the WB result is visible to the same-cycle ID read.
   assign rd1 = (ra1 == 5'd0) ? '0 : (we && wa == ra1) ? wd : registers[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : (we && wa == ra2) ? wd : registers[ra2];
endmodule

module mips_decode
   import mips_pipeline_wrapper_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  if_id_t      if_id,
   input  logic        wb_we,
   input  logic [4:0]  wb_dest,
   input  logic [31:0] wb_data,
   output id_ex_t      dec,
   output logic        jump,
   output logic [31:0] jump_target
);
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd;
   logic [31:0] rs_val, rt_val;
   logic        unused_shamt;

   assign op           = if_id.instr[31:26];
   assign rs           = if_id.instr[25:21];
   assign rt           = if_id.instr[20:16];
   assign rd           = if_id.instr[15:11];
   assign funct        = if_id.instr[5:0];
   assign unused_shamt = ^if_id.instr[10:6];
   assign jump         = (op == OP_J);
   assign jump_target  = {if_id.pc1[31:26], if_id.instr[25:0]};

   mips_regfile RegisterFile (
      .clk(clk), .rst(rst), .ra1(rs), .ra2(rt),
      .we(wb_we), .wa(wb_dest), .wd(wb_data), .rd1(rs_val), .rd2(rt_val)
   );

   always_comb begin
      dec        = '0;
      dec.rs     = rs;
      dec.rt     = rt;
      dec.rs_val = rs_val;
      dec.rt_val = rt_val;
      dec.imm    = {{16{if_id.instr[15]}}, if_id.instr[15:0]};
      dec.pc1    = if_id.pc1;
      case (op)
         OP_RTYPE: begin
            dec.dest      = rd;
            dec.reg_write = 1'b1;
            case (funct)
               FN_ADD:  dec.alu_op = ALU_ADD;
               FN_AND:  dec.alu_op = ALU_AND;
               FN_OR:   dec.alu_op = ALU_OR;
               FN_SLT:  dec.alu_op = ALU_SLT;
               default: dec.reg_write = 1'b0;
            endcase
         end
         OP_ADDI: begin dec.reg_write = 1'b1; dec.dest = rt; dec.alu_src = 1'b1; end
         OP_LW:   begin dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.dest = rt; dec.alu_src = 1'b1; end
         OP_SW:   begin dec.mem_write = 1'b1; dec.alu_src = 1'b1; end
         OP_BEQ:  dec.branch = 1'b1;
         default: ;
      endcase
      // Writes to $0 are dropped here, which also keeps $0 out of forwarding.
      if (dec.dest == 5'd0) dec.reg_write = 1'b0;
   end
endmodule

module mips_execute
   import mips_pipeline_wrapper_pkg::*;
(
   input  id_ex_t      id_ex,
   input  fwd_sel_e    fwd_a,
   input  fwd_sel_e    fwd_b,
   input  logic [31:0] mem_fwd,
   input  logic [31:0] wb_fwd,
   output ex_mem_t     ex_mem,
   output logic        branch_taken,
   output logic [31:0] branch_target
);
   logic [31:0] opa, rt_fwd, opb, res;
   logic        unused_regs;

   assign unused_regs = ^{id_ex.rs, id_ex.rt};

   always_comb begin
      case (fwd_a)
         FWD_MEM: opa = mem_fwd;
         FWD_WB:  opa = wb_fwd;
         default: opa = id_ex.rs_val;
      endcase
      case (fwd_b)
         FWD_MEM: rt_fwd = mem_fwd;
         FWD_WB:  rt_fwd = wb_fwd;
         default: rt_fwd = id_ex.rt_val;
      endcase
      opb = id_ex.alu_src ? id_ex.imm : rt_fwd;
      case (id_ex.alu_op)
         ALU_AND: res = opa & opb;
         ALU_OR:  res = opa | opb;
         ALU_SLT: res = {31'd0, $signed(opa) < $signed(opb)};
         default: res = opa + opb;
      endcase
   end

   assign branch_taken  = id_ex.branch && (opa == rt_fwd);
   assign branch_target = id_ex.pc1 + id_ex.imm;
   assign ex_mem = '{reg_write: id_ex.reg_write, mem_read: id_ex.mem_read,
                     mem_write: id_ex.mem_write, dest: id_ex.dest,
                     alu_res: res, store_val: rt_fwd};
endmodule

module mips_memaccess
   import mips_pipeline_wrapper_pkg::*;
#(parameter int DEPTH = 256)
(
   input  logic    clk,
   input  ex_mem_t ex_mem,
   output mem_wb_t mem_wb
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0] rdata;

   mips_dmem #(.DEPTH(DEPTH)) DataMemory (
      .clk(clk), .we(ex_mem.mem_write), .addr(ex_mem.alu_res[AW-1:0]),
      .wdata(ex_mem.store_val), .rdata(rdata)
   );

   assign mem_wb = '{reg_write: ex_mem.reg_write, mem_read: ex_mem.mem_read,
                     dest: ex_mem.dest, alu_res: ex_mem.alu_res, load_val: rdata};
endmodule

module mips_writeback
   import mips_pipeline_wrapper_pkg::*;
(
   input  mem_wb_t     mem_wb,
   output logic        we,
   output logic [4:0]  dest,
   output logic [31:0] data
);
   assign we   = mem_wb.reg_write;
   assign dest = mem_wb.dest;
   assign data = mem_wb.mem_read ? mem_wb.load_val : mem_wb.alu_res;
endmodule

// File: rtl/mips_pipeline_wrapper.sv
// 5-stage MIPS-subset CPU with private instruction/data memories; owns the PC
// and the four pipeline registers, stage logic lives in the stage modules.
module mips_pipeline_wrapper
   import mips_pipeline_wrapper_pkg::*;
#(
   parameter int IMEM_DEPTH = 256,
   parameter int DMEM_DEPTH = 256
)
(
   input  logic clock,
   input  logic resetMachine
);
   localparam int IAW = $clog2(IMEM_DEPTH);

   logic [31:0] pc_q, pc_d, pc_plus1, instr;
   logic [31:0] jump_target, branch_target, wb_data;
   logic [4:0]  wb_dest;
   logic        jump, branch_taken, stall, flush_if_id, flush_id_ex, wb_we;
   fwd_sel_e    fwd_a, fwd_b;
   if_id_t      if_id_q, if_id_d;
   id_ex_t      id_ex_q, id_ex_d, dec;
   ex_mem_t     ex_mem_q, ex_mem_d;
   mem_wb_t     mem_wb_q, mem_wb_d;

   assign pc_plus1 = pc_q + 32'd1;

   mips_fetch #(.DEPTH(IMEM_DEPTH)) FetchMIPS (.pc_idx(pc_q[IAW-1:0]), .instr(instr));

   mips_decode DecodeMIPS (
      .clk(clock), .rst(resetMachine), .if_id(if_id_q), .wb_we(wb_we),
      .wb_dest(wb_dest), .wb_data(wb_data), .dec(dec), .jump(jump),
      .jump_target(jump_target)
   );

   mips_pipeline_wrapper_hazard_unit u_hazard (
      .id_rs(dec.rs), .id_rt(dec.rt), .ex_mem_read(id_ex_q.mem_read),
      .ex_rs(id_ex_q.rs), .ex_rt(id_ex_q.rt),
      .mem_reg_write(ex_mem_q.reg_write), .mem_dest(ex_mem_q.dest),
      .wb_reg_write(mem_wb_q.reg_write), .wb_dest(mem_wb_q.dest),
      .branch_taken(branch_taken), .jump(jump), .fwd_a(fwd_a), .fwd_b(fwd_b),
      .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex)
   );

   mips_execute ExecuteMIPS (
      .id_ex(id_ex_q), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(ex_mem_q.alu_res),
      .wb_fwd(wb_data), .ex_mem(ex_mem_d), .branch_taken(branch_taken),
      .branch_target(branch_target)
   );

   mips_memaccess #(.DEPTH(DMEM_DEPTH)) MemoryAccessMIPS (
      .clk(clock), .ex_mem(ex_mem_q), .mem_wb(mem_wb_d)
   );

   mips_writeback WriteBackMIPS (
      .mem_wb(mem_wb_q), .we(wb_we), .dest(wb_dest), .data(wb_data)
   );

   always_comb begin
      pc_d    = pc_plus1;
      if_id_d = '{pc1: pc_plus1, instr: instr};
      id_ex_d = dec;
      if (branch_taken) pc_d = branch_target;
      else if (stall)   pc_d = pc_q;
      else if (jump)    pc_d = jump_target;
      if (flush_if_id)  if_id_d = IF_ID_BUBBLE;
      else if (stall)   if_id_d = if_id_q;
      if (flush_id_ex)  id_ex_d = '0;
   end

   always_ff @(posedge clock or posedge resetMachine) begin
      if (resetMachine) begin
         pc_q     <= '0;
         if_id_q  <= IF_ID_BUBBLE;
         id_ex_q  <= '0;
         ex_mem_q <= '0;
         mem_wb_q <= '0;
      end else begin
         pc_q     <= pc_d;
         if_id_q  <= if_id_d;
         id_ex_q  <= id_ex_d;
         ex_mem_q <= ex_mem_d;
         mem_wb_q <= mem_wb_d;
      end
   end
endmodule

// File: tb/tb_mips_pipeline_wrapper.sv
// Directed programs loaded into the CPU memories; register/memory/PC state
// compared against hand-computed values.
module tb_mips_pipeline_wrapper;
   logic clock = 1'b0;
   logic resetMachine = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   int   exp_pc [5] = '{1, 2, 2, 3, 4};

   mips_pipeline_wrapper #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
      .clock(clock), .resetMachine(resetMachine)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [4:0] rt);
      return {6'h00, rs, rt, rd, 5'h00, fn};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                         input logic [4:0] rs, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] enc_j(input logic [25:0] t);
      return {6'h02, t};
   endfunction

   function automatic logic [31:0] rf(input int i);
      return dut.DecodeMIPS.RegisterFile.registers[i];
   endfunction
   function automatic logic [31:0] rf_or();
      logic [31:0] acc = '0;
      for (int i = 0; i < 32; i++) acc |= dut.DecodeMIPS.RegisterFile.registers[i];
      return acc;
   endfunction
   function automatic logic [31:0] dmem(input int a);
      return dut.MemoryAccessMIPS.DataMemory.memory[a];
   endfunction

   task automatic ld(input int a, input logic [31:0] w);
      dut.FetchMIPS.InstructionMemory.memory[a] = w;
   endtask
   task automatic dm(input int a, input logic [31:0] w);
      dut.MemoryAccessMIPS.DataMemory.memory[a] = w;
   endtask
   task automatic hold_reset();
      @(negedge clock);
      resetMachine = 1'b1;
      for (int i = 0; i < 256; i++) dut.FetchMIPS.InstructionMemory.memory[i] = 32'h0000_0020;
   endtask
   task automatic release_reset();
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetMachine = 1'b0;
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      int cnt;
      logic bad;

      // reset and idle on power-up memory contents
      repeat (2) @(posedge clock);
      #1;
      chk("rst_pc", dut.pc_q, 32'd0);
      chk("rst_regs", rf_or(), 32'd0);
      @(negedge clock);
      resetMachine = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk("idle_pc", dut.pc_q, k);
      end
      step(16);
      chk("idle_pc20", dut.pc_q, 32'd20);
      chk("idle_regs", rf_or(), 32'd0);

      // load/ALU program
      hold_reset();
      dm(0, 32'h0010ABCF); dm(2, 32'hF0000029); dm(8, 32'h8F02F214);
      dm(9, 32'h1042AABB); dm(10, 32'hC0CAC01A);
      ld(0,  enc_i(6'h23, 0, 0, 16'd0));
      ld(1,  enc_i(6'h23, 2, 0, 16'd8));
      ld(2,  enc_i(6'h23, 4, 0, 16'd9));
      ld(3,  enc_r(6'h20, 2, 2, 4));
      ld(4,  enc_r(6'h24, 3, 2, 4));
      ld(5,  enc_i(6'h23, 5, 0, 16'd10));
      ld(6,  enc_r(6'h25, 7, 5, 0));
      ld(7,  enc_i(6'h23, 6, 0, 16'd2));
      ld(8,  enc_r(6'h25, 7, 7, 6));
      ld(9,  enc_r(6'h2A, 10, 0, 7));
      ld(10, enc_r(6'h2A, 11, 7, 0));
      ld(11, enc_i(6'h08, 31, 0, 16'hFFFF));
      ld(12, enc_j(26'd14));
      ld(13, enc_i(6'h04, 0, 0, 16'hFFFF));
      ld(14, enc_j(26'd14));
      release_reset();
      step(300);
      chk("t1_r0", rf(0), 32'h0);
      chk("t1_r2", rf(2), 32'h9F459CCF);
      chk("t1_r3", rf(3), 32'h1040888B);
      chk("t1_r4", rf(4), 32'h1042AABB);
      chk("t1_r5", rf(5), 32'hC0CAC01A);
      chk("t1_r6", rf(6), 32'hF0000029);
      chk("t1_r7", rf(7), 32'hF0CAC03B);
      chk("t1_r10", rf(10), 32'h0);
      chk("t1_r11", rf(11), 32'h1);
      chk("t1_r31", rf(31), 32'hFFFFFFFF);
      cnt = 0;
      bad = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step(1);
         if (dut.pc_q == 32'd14) cnt++;
         else if (dut.pc_q != 32'd15) bad = 1'b1;
      end
      chk("t1_park_at14", cnt, 32'd4);
      chk("t1_park_range", {31'd0, bad}, 32'd0);

      // minimum search
      hold_reset();
      dm(0, 32'h0010ABCF); dm(1, 32'h10420010); dm(2, 32'hF0000029); dm(3, 32'hFFFFFFFF);
      dm(4, 32'hA0BF5978); dm(5, 32'hB0231234); dm(6, 32'h10241548); dm(7, 32'h7015ABCD);
      dm(8, 32'h80000000); dm(9, 32'h1042AABB); dm(13, 32'h0);
      ld(0,  enc_i(6'h08, 1, 0, 16'd0));
      ld(1,  enc_i(6'h08, 2, 0, 16'd9));
      ld(2,  enc_i(6'h23, 3, 0, 16'd0));
      ld(3,  enc_i(6'h04, 2, 1, 16'd6));
      ld(4,  enc_i(6'h08, 1, 1, 16'd1));
      ld(5,  enc_i(6'h23, 4, 1, 16'd0));
      ld(6,  enc_r(6'h2A, 5, 4, 3));
      ld(7,  enc_i(6'h04, 0, 5, 16'hFFFB));
      ld(8,  enc_r(6'h20, 3, 4, 0));
      ld(9,  enc_j(26'd3));
      ld(10, enc_i(6'h2B, 3, 1, 16'd4));
      ld(11, enc_j(26'd11));
      release_reset();
      step(400);
      chk("min_dmem13", dmem(13), 32'h80000000);
      chk("min_r1", rf(1), 32'd9);
      chk("min_r2", rf(2), 32'd9);
      chk("min_r3", rf(3), 32'h80000000);
      chk("min_r4", rf(4), 32'h1042AABB);
      chk("min_r5", rf(5), 32'd0);

      // load-use: one stall cycle visible as a repeated PC
      hold_reset();
      dm(20, 32'h12345678);
      ld(0, enc_i(6'h23, 4, 0, 16'd20));
      ld(1, enc_r(6'h20, 5, 4, 4));
      ld(2, enc_i(6'h08, 6, 0, 16'd7));
      ld(3, enc_j(26'd3));
      release_reset();
      for (int k = 0; k < 5; k++) begin
         step(1);
         chk("lu_pc", dut.pc_q, exp_pc[k]);
      end
      step(20);
      chk("lu_r4", rf(4), 32'h12345678);
      chk("lu_r5", rf(5), 32'h2468ACF0);
      chk("lu_r6", rf(6), 32'd7);

      // taken beq in EX beats j in ID; wrong path never commits
      hold_reset();
      ld(0, enc_i(6'h04, 0, 0, 16'd2));
      ld(1, enc_j(26'd5));
      ld(2, enc_i(6'h08, 9, 0, 16'd1));
      ld(3, enc_i(6'h08, 8, 0, 16'd3));
      ld(4, enc_j(26'd4));
      ld(5, enc_i(6'h08, 9, 0, 16'd1));
      ld(6, enc_j(26'd6));
      release_reset();
      step(30);
      chk("beq_r9", rf(9), 32'd0);
      chk("beq_r8", rf(8), 32'd3);

      // jump flush
      hold_reset();
      ld(0, enc_j(26'd2));
      ld(1, enc_i(6'h08, 9, 0, 16'd1));
      ld(2, enc_i(6'h08, 8, 0, 16'd4));
      ld(3, enc_j(26'd3));
      release_reset();
      step(30);
      chk("j_r9", rf(9), 32'd0);
      chk("j_r8", rf(8), 32'd4);

      // reset while a store is in EX/MEM
      hold_reset();
      dm(40, 32'h0000AAAA); dm(41, 32'h0000BBBB);
      ld(0, enc_i(6'h08, 1, 0, 16'h0055));
      ld(1, enc_i(6'h2B, 1, 0, 16'd40));
      ld(2, enc_i(6'h08, 1, 0, 16'h0077));
      ld(3, enc_i(6'h2B, 1, 0, 16'd41));
      ld(4, enc_j(26'd4));
      release_reset();
      step(6);
      chk("mr_r1_pre", rf(1), 32'h55);
      chk("mr_d40_pre", dmem(40), 32'h55);
      #1;
      resetMachine = 1'b1;
      #1;
      chk("mr_pc", dut.pc_q, 32'd0);
      chk("mr_regs", rf_or(), 32'd0);
      step(2);
      chk("mr_d41", dmem(41), 32'h0000BBBB);
      chk("mr_d40", dmem(40), 32'h55);
      chk("mr_d13_kept", dmem(13), 32'h80000000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
